// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm clock: operating modes, active-low
// seven-segment digit patterns (bit6=g .. bit0=a) and wrap-around increments.
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_CLK = 2'b01,
        MODE_SET_ALM = 2'b10,
        MODE_RING    = 2'b11
    } mode_e;

    localparam logic [6:0] SEG7_0     = 7'b1000000;
    localparam logic [6:0] SEG7_1     = 7'b1111001;
    localparam logic [6:0] SEG7_2     = 7'b0100100;
    localparam logic [6:0] SEG7_3     = 7'b0110000;
    localparam logic [6:0] SEG7_4     = 7'b0011001;
    localparam logic [6:0] SEG7_5     = 7'b0010010;
    localparam logic [6:0] SEG7_6     = 7'b0000010;
    localparam logic [6:0] SEG7_7     = 7'b1111000;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0010000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_to_seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG7_0;
            4'd1:    return SEG7_1;
            4'd2:    return SEG7_2;
            4'd3:    return SEG7_3;
            4'd4:    return SEG7_4;
            4'd5:    return SEG7_5;
            4'd6:    return SEG7_6;
            4'd7:    return SEG7_7;
            4'd8:    return SEG7_8;
            4'd9:    return SEG7_9;
            default: return SEG7_BLANK;
        endcase
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle press pulse
// when a 0->1 change has held for DEB_CYCLES consecutive samples.
module button_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                stable_d = sync_q[1];
                press_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous (sampled on the edge) and all state uses non-blocking assignments.
        if (!rst_ni) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock: prescaled hh:mm:ss timekeeping, set-clock / set-alarm modes,
// ringing with auto-stop, and registered seven-segment / LED / buzzer outputs.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int RING_SECS  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    input  logic       button1,
    input  logic       button2,
    output logic [1:0] leds,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic       buzz
);
    localparam int PW = $clog2(CLK_HZ + 1);
    localparam int RW = $clog2(RING_SECS + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

    mode_e         state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hh_q, hh_d, alm_hh_q, alm_hh_d, inc_hh, disp_hh;
    logic [5:0]    mm_q, mm_d, ss_q, ss_d, alm_mm_q, alm_mm_d, inc_mm, inc_ss, disp_mm;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [1:0]    leds_q;
    logic [6:0]    seg1_q, seg2_q, seg3_q, seg4_q;
    logic          buzz_q;
    logic          press1, press2, tick, alarm_hit, ring_done;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hours (
        .clk_i(clk), .rst_ni(reset), .btn_i(button1), .press_o(press1)
    );
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_minutes (
        .clk_i(clk), .rst_ni(reset), .btn_i(button2), .press_o(press2)
    );

    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        inc_ss = ss_q;
        inc_mm = mm_q;
        inc_hh = hh_q;
        if (tick) begin
            inc_ss = inc_mod60(ss_q);
            if (ss_q == 6'd59) begin
                inc_mm = inc_mod60(mm_q);
                if (mm_q == 6'd59) begin
                    inc_hh = inc_mod24(hh_q);
                end
            end
        end
    end

    // The alarm fires on the tick that lands exactly on alm_hh:alm_mm:00.
    assign alarm_hit = tick && !switch4 && !switch1 && (inc_hh == alm_hh_q)
                       && (inc_mm == alm_mm_q) && (inc_ss == 6'd0);
    assign ring_done = tick && (ring_cnt_q == RW'(RING_SECS - 1));

    always_comb begin
        state_d = state_q;
        if (switch2) begin
            state_d = MODE_SET_CLK;
        end else if (switch3) begin
            state_d = MODE_SET_ALM;
        end else begin
            case (state_q)
                MODE_RUN:  if (alarm_hit) state_d = MODE_RING;
                MODE_RING: if (switch4 || press1 || press2 || ring_done) state_d = MODE_RUN;
                default:   state_d = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        ss_d       = inc_ss;
        mm_d       = inc_mm;
        hh_d       = inc_hh;
        alm_hh_d   = alm_hh_q;
        alm_mm_d   = alm_mm_q;
        ring_cnt_d = '0;
        case (state_q)
            MODE_SET_CLK: begin
                presc_d = '0;
                ss_d    = '0;
                hh_d    = press1 ? inc_mod24(hh_q) : hh_q;
                mm_d    = press2 ? inc_mod60(mm_q) : mm_q;
            end
            MODE_SET_ALM: begin
                if (press1) alm_hh_d = inc_mod24(alm_hh_q);
                if (press2) alm_mm_d = inc_mod60(alm_mm_q);
            end
            MODE_RING: ring_cnt_d = tick ? ring_cnt_q + RW'(1) : ring_cnt_q;
            default: ;
        endcase
        if (switch1) begin
            presc_d = '0;
            hh_d    = '0;
            mm_d    = '0;
            ss_d    = '0;
        end
    end

    // Outputs register the next-state view so they change on the same edge as the state.
    assign disp_hh = (state_d == MODE_SET_ALM) ? alm_hh_d : hh_d;
    assign disp_mm = (state_d == MODE_SET_ALM) ? alm_mm_d : mm_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= MODE_RUN;
            presc_q    <= '0;
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            alm_hh_q   <= 5'd6;
            alm_mm_q   <= '0;
            ring_cnt_q <= '0;
            leds_q     <= MODE_RUN;
            seg1_q     <= SEG7_0;
            seg2_q     <= SEG7_0;
            seg3_q     <= SEG7_0;
            seg4_q     <= SEG7_0;
            buzz_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            alm_hh_q   <= alm_hh_d;
            alm_mm_q   <= alm_mm_d;
            ring_cnt_q <= ring_cnt_d;
            leds_q     <= state_d;
            seg1_q     <= digit_to_seg7(4'(disp_hh / 5'd10));
            seg2_q     <= digit_to_seg7(4'(disp_hh % 5'd10));
            seg3_q     <= digit_to_seg7(4'(disp_mm / 6'd10));
            seg4_q     <= digit_to_seg7(4'(disp_mm % 6'd10));
            buzz_q     <= (state_d == MODE_RING) && (presc_d < PRESC_HALF);
        end
    end

    assign leds = leds_q;
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign seg3 = seg3_q;
    assign seg4 = seg4_q;
    assign buzz = buzz_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with CLK_HZ=10, DEB_CYCLES=3, RING_SECS=5;
// inputs change and outputs are sampled on the falling clock edge.
module tb_alarm_ctrl;

    localparam logic [31:0] S0 = 32'(7'b1000000);
    localparam logic [31:0] S1 = 32'(7'b1111001);
    localparam logic [31:0] S2 = 32'(7'b0100100);
    localparam logic [31:0] S3 = 32'(7'b0110000);
    localparam logic [31:0] S5 = 32'(7'b0010010);
    localparam logic [31:0] S6 = 32'(7'b0000010);
    localparam logic [31:0] S9 = 32'(7'b0010000);

    logic       clk = 1'b0;
    logic       reset, switch1, switch2, switch3, switch4, button1, button2;
    logic [1:0] leds;
    logic [6:0] seg1, seg2, seg3, seg4;
    logic       buzz;
    int         n_checks = 0;
    int         n_fail = 0;

    alarm_ctrl #(.CLK_HZ(10), .DEB_CYCLES(3), .RING_SECS(5)) dut (
        .clk(clk), .reset(reset),
        .switch1(switch1), .switch2(switch2), .switch3(switch3), .switch4(switch4),
        .button1(button1), .button2(button2),
        .leds(leds), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .buzz(buzz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input int hold);
        if (which == 1) button1 = 1'b1;
        else            button2 = 1'b1;
        step(hold);
        button1 = 1'b0;
        button2 = 1'b0;
        step(6);
    endtask

    task automatic clear_time();
        switch1 = 1'b1;
        step(2);
        switch1 = 1'b0;
    endtask

    task automatic check_display(input string tag, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3, input logic [31:0] d4);
        check({tag, "_seg1"}, 32'(seg1), d1);
        check({tag, "_seg2"}, 32'(seg2), d2);
        check({tag, "_seg3"}, 32'(seg3), d3);
        check({tag, "_seg4"}, 32'(seg4), d4);
    endtask

    initial begin
        reset = 1'b0; switch1 = 1'b0; switch2 = 1'b0; switch3 = 1'b0; switch4 = 1'b0;
        button1 = 1'b0; button2 = 1'b0;
        step(3);
        check("rst_leds", 32'(leds), 0);
        check("rst_buzz", 32'(buzz), 0);
        reset = 1'b1;
        step(1);
        check_display("rel", S0, S0, S0, S0);
        check("rel_leds", 32'(leds), 0);

        // 60 seconds after release: still 00:00 one cycle before, 00:01 on the 60th tick.
        step(598);
        check("pre_min_seg4", 32'(seg4), S0);
        step(1);
        check_display("min1", S0, S0, S0, S1);

        // Set clock: glitch rejection, single accepted press, mm wrap without carry.
        switch2 = 1'b1;
        step(2);
        check("setclk_leds", 32'(leds), 1);
        press(1, 2);
        check("glitch_hh", 32'(seg2), S0);
        press(1, 3);
        check("press_hh", 32'(seg2), S1);
        for (int i = 0; i < 22; i++) press(1, 3);
        for (int i = 0; i < 58; i++) press(2, 3);
        check_display("set2359", S2, S3, S5, S9);
        press(2, 3);
        check_display("mm_wrap", S2, S3, S0, S0);
        for (int i = 0; i < 59; i++) press(2, 3);
        switch2 = 1'b0;
        step(600);
        check_display("pre_wrap", S2, S3, S5, S9);
        step(1);
        check_display("day_wrap", S0, S0, S0, S0);
        check("run_leds", 32'(leds), 0);

        // Set alarm to 00:01; display shows the alarm in this mode.
        switch3 = 1'b1;
        step(2);
        check("setalm_leds", 32'(leds), 2);
        check_display("alm_dflt", S0, S6, S0, S0);
        for (int i = 0; i < 18; i++) press(1, 3);
        press(2, 3);
        check_display("alm_0001", S0, S0, S0, S1);
        switch3 = 1'b0;

        // Ring 1: buzz pattern then auto-stop after 5 ticks.
        clear_time();
        step(599);
        check("pre_ring_leds", 32'(leds), 0);
        check("pre_ring_buzz", 32'(buzz), 0);
        step(1);
        check("ring_leds", 32'(leds), 3);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("buzz_c%0d", i), 32'(buzz), (i < 5) ? 1 : 0);
            step(1);
        end
        check("buzz_sec2", 32'(buzz), 1);
        step(39);
        check("ring_last_leds", 32'(leds), 3);
        step(1);
        check("auto_stop_leds", 32'(leds), 0);
        check("auto_stop_buzz", 32'(buzz), 0);

        // Ring 2: disarm switch stops ringing on the next edge.
        clear_time();
        step(600);
        check("ring2_leds", 32'(leds), 3);
        step(3);
        switch4 = 1'b1;
        step(1);
        check("sw4_leds", 32'(leds), 0);
        check("sw4_buzz", 32'(buzz), 0);
        switch4 = 1'b0;

        // Ring 3: set-alarm switch aborts ringing.
        clear_time();
        step(600);
        check("ring3_leds", 32'(leds), 3);
        step(2);
        switch3 = 1'b1;
        step(1);
        check("abort_leds", 32'(leds), 2);
        check("abort_buzz", 32'(buzz), 0);
        switch3 = 1'b0;
        step(2);

        // Ring 4: reset mid-ring restores reset outputs and the default alarm.
        clear_time();
        step(600);
        check("ring4_leds", 32'(leds), 3);
        step(2);
        check("ring4_buzz", 32'(buzz), 1);
        reset = 1'b0;
        step(1);
        check("rst_ring_leds", 32'(leds), 0);
        check("rst_ring_buzz", 32'(buzz), 0);
        check_display("rst_ring", S0, S0, S0, S0);
        reset = 1'b1;
        step(1);
        check_display("rst_rel2", S0, S0, S0, S0);
        switch3 = 1'b1;
        step(2);
        check_display("alm_after_rst", S0, S6, S0, S0);
        switch3 = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000: clk cycles per second tick.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 500000: cycles a button must be stable before it is accepted.
REQ-003 The block SHALL have parameter RING_SECS, default 60: seconds of ringing before auto-stop.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 switch1  in  1  clear time (switch_reset).
REQ-007 switch2  in  1  set-clock mode.
REQ-008 switch3  in  1  set-alarm mode.
REQ-009 switch4  in  1  alarm off (1 = disarmed).
REQ-010 button1  in  1  hours increment, raw.
REQ-011 button2  in  1  minutes increment, raw.
REQ-012 leds  out  2  mode: 00 RUN, 01 SET_CLK, 10 SET_ALM, 11 RING.
REQ-013 seg1..seg4  out  7 each  active-low digits, bit6=g..bit0=a; seg1 = hours tens, seg4 = minutes units.
REQ-014 buzz  out  1  buzzer drive, active-high.

Function
REQ-015 The prescaler SHALL count 0..CLK_HZ-1 and emit a one-cycle tick on the wrap.
REQ-016 Time SHALL be hh 0-23, mm 0-59, ss 0-59 with carries on tick; 23:59:59 SHALL wrap to 00:00:00.
REQ-017 Each button SHALL be accepted only after DEB_CYCLES consecutive stable samples; an accepted 0->1 transition SHALL yield exactly one press pulse.
REQ-018 The FSM states SHALL be RUN, SET_CLK, SET_ALM, RING; priority SHALL be switch2 > switch3 > RING > RUN.
REQ-019 SET_CLK: ss SHALL be held at 0 and the prescaler at 0; button1 SHALL add 1 to hh mod 24; button2 SHALL add 1 to mm mod 60 with no carry into hh.
REQ-020 SET_ALM: buttons SHALL edit alarm hh/mm with the same rules while time keeps running.
REQ-021 RUN->RING SHALL occur on the tick that makes time equal alarm_hh:alarm_mm:00 when switch4=0.
REQ-022 RING->RUN SHALL occur on switch4=1, any button press, or after RING_SECS ticks, on the next clock edge.
REQ-023 switch2 or switch3 asserted during RING SHALL abort ringing into the set mode.
REQ-024 buzz SHALL be 1 in RING while prescaler < CLK_HZ/2, else 0; buzz SHALL be 0 in all other states.
REQ-025 switch1=1 SHALL force time to 00:00:00 and the prescaler to 0 each cycle; the alarm and FSM state SHALL be unaffected.
REQ-026 Displays SHALL show alarm in SET_ALM and time otherwise; all outputs SHALL be registered (1-cycle latency).

Reset
REQ-027 reset=0 SHALL set time 00:00:00, alarm 06:00, prescaler 0, debouncers idle, state RUN.
REQ-028 After reset: leds=00, buzz=0, and seg1..seg4 = 7'b1000000 ("0") on the first edge after release.
REQ-029 Reset asserted mid-RING SHALL drive buzz=0 at the next edge.

Structure
REQ-030 A package alarm_pkg SHALL hold the mode enum, the seg7 digit constants, and a digit-to-seg7 function.
REQ-031 One sub-module, button_debounce (DEB_CYCLES parameter, press-pulse output), SHALL be instantiated twice.

Verification (CLK_HZ=10, DEB_CYCLES=3, RING_SECS=5)
REQ-032 Reset, then 60 ticks -> seg3=7'b1000000, seg4=7'b1111001 (00:01).
REQ-033 SET_CLK with hh=23, mm=59 set, release to RUN, 60 ticks -> display 00:00.
REQ-034 SET_CLK with a 2-cycle button1 glitch -> hh unchanged; 3-cycle stable press -> hh+1 exactly once.
REQ-035 Alarm 00:01, switch4=0, 60 ticks -> leds=11 and buzz 1 for 5 cycles / 0 for 5 cycles; after 5 ticks -> leds=00, buzz=0.
REQ-036 During RING, switch4=1 -> leds=00, buzz=0 next edge; separately, reset=0 mid-RING -> REQ-028 values.
